// File: rtl/img_coord_pkg.sv
// Shared types and helpers for the pixel-coordinate generator.
package img_coord_pkg;

   // Width helper that never returns 0, so a 1-value range still gets a bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   // Per-pixel position flags registered alongside the pixel.
   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
      logic border;
   } coord_flags_t;

endpackage

// File: rtl/img_coord_gen_if.sv
// Pixel stream in/out bundle for img_coord_gen.
// IMG_COORD_SOF_RESYNC_EN adds din_sof and sync_err.
interface img_coord_gen_if #(
   parameter int DIN_DATA_WIDTH = 8,
   parameter int COL_W          = 10,
   parameter int ROW_W          = 9,
   parameter int FRAME_W        = 8
);
   logic                      din_valid;
   logic [DIN_DATA_WIDTH-1:0] din_data;
   logic                      dout_valid;
   logic [DIN_DATA_WIDTH-1:0] dout_data;
   logic [COL_W-1:0]          col_cnt;
   logic [ROW_W-1:0]          row_cnt;
   logic                      sof;
   logic                      eol;
   logic                      eof;
   logic                      border;
   logic [FRAME_W-1:0]        frame_cnt;
`ifdef IMG_COORD_SOF_RESYNC_EN
   logic                      din_sof;
   logic                      sync_err;
`endif

   // Pixel source side.
   modport master (
      output din_valid, din_data,
`ifdef IMG_COORD_SOF_RESYNC_EN
      output din_sof,
      input  sync_err,
`endif
      input  dout_valid, dout_data, col_cnt, row_cnt,
      input  sof, eol, eof, border, frame_cnt
   );

   // Coordinate generator side.
   modport slave (
      input  din_valid, din_data,
`ifdef IMG_COORD_SOF_RESYNC_EN
      input  din_sof,
      output sync_err,
`endif
      output dout_valid, dout_data, col_cnt, row_cnt,
      output sof, eol, eof, border, frame_cnt
   );
endinterface

// File: rtl/img_coord_gen_wrap_counter.sv
// Modulo-(MAX+1) counter with enable and synchronous load; load wins over en.
module wrap_counter #(
   parameter int MAX = 3,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         at_max
);
   localparam logic [W-1:0] LP_MAX = W'(MAX);

   logic [W-1:0] r_cnt;

   assign cnt    = r_cnt;
   assign at_max = (r_cnt == LP_MAX);

   // Explicit wrap compare, so power-of-two ranges behave like any other.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_cnt <= '0;
      else if (load)   r_cnt <= load_val;
      else if (en)     r_cnt <= at_max ? '0 : r_cnt + W'(1);
   end
endmodule

// File: rtl/img_coord_gen.sv
// Pixel-coordinate generator: registers each valid pixel with its (col,row),
// frame markers, border flag and completed-frame count. One cycle latency.
// Optional: IMG_COORD_SOF_RESYNC_EN realigns to (0,0) on din_sof.
module img_coord_gen
   import img_coord_pkg::*;
#(
   parameter int DIN_DATA_WIDTH = 8,
   parameter int COL            = 640,
   parameter int ROW            = 480,
   parameter int COL_W          = clog2_min1(COL),
   parameter int ROW_W          = clog2_min1(ROW),
   parameter int BORDER         = 1,
   parameter int FRAME_W        = 8
) (
   input  logic           clk,
   input  logic           rst,
   img_coord_gen_if.slave bus
);
   localparam logic [COL_W-1:0] LP_COL_LO = COL_W'(BORDER);
   localparam logic [COL_W-1:0] LP_COL_HI = COL_W'(COL - BORDER);
   localparam logic [ROW_W-1:0] LP_ROW_LO = ROW_W'(BORDER);
   localparam logic [ROW_W-1:0] LP_ROW_HI = ROW_W'(ROW - BORDER);

   logic                      w_acc;
   logic                      w_load;
   logic [COL_W-1:0]          w_col;
   logic [ROW_W-1:0]          w_row;
   logic                      w_col_max;
   logic                      w_row_max;
   logic [COL_W-1:0]          w_pix_col;
   logic [ROW_W-1:0]          w_pix_row;
   coord_flags_t              w_flags;

   logic                      r_dout_valid;
   logic [DIN_DATA_WIDTH-1:0] r_dout_data;
   logic [COL_W-1:0]          r_col;
   logic [ROW_W-1:0]          r_row;
   coord_flags_t              r_flags;
   logic [FRAME_W-1:0]        r_frame;

   assign w_acc = bus.din_valid;

`ifdef IMG_COORD_SOF_RESYNC_EN
   logic w_serr;
   logic r_serr;
   // A resync forces the current pixel to (0,0); it only flags an error if
   // the free-running position disagreed.
   assign w_load = bus.din_valid & bus.din_sof;
   assign w_serr = w_load & ((w_col != '0) | (w_row != '0));
   assign bus.sync_err = r_serr;

   // One-cycle error pulse, aligned with the resynced pixel on dout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_serr <= 1'b0;
      else     r_serr <= w_serr;
   end
`else
   assign w_load = 1'b0;
`endif

   // Column counter: next pixel's column. A resync loads 1 (the pixel after (0,0)).
   wrap_counter #(.MAX(COL - 1), .W(COL_W)) u_col (
      .clk      (clk),
      .rst      (rst),
      .en       (w_acc),
      .load     (w_load),
      .load_val (COL_W'(1)),
      .cnt      (w_col),
      .at_max   (w_col_max)
   );

   // Row counter: steps when the accepted pixel closes a line.
   wrap_counter #(.MAX(ROW - 1), .W(ROW_W)) u_row (
      .clk      (clk),
      .rst      (rst),
      .en       (w_acc & w_col_max),
      .load     (w_load),
      .load_val ('0),
      .cnt      (w_row),
      .at_max   (w_row_max)
   );

   assign w_pix_col = w_load ? '0 : w_col;
   assign w_pix_row = w_load ? '0 : w_row;

   // Flags of the pixel being accepted this cycle.
   always_comb begin
      w_flags        = '0;
      w_flags.sof    = (w_pix_col == '0) && (w_pix_row == '0);
      w_flags.eol    = ~w_load & w_col_max;
      w_flags.eof    = ~w_load & w_col_max & w_row_max;
      w_flags.border = (w_pix_col < LP_COL_LO) || (w_pix_col >= LP_COL_HI) ||
                       (w_pix_row < LP_ROW_LO) || (w_pix_row >= LP_ROW_HI);
   end

   // Output register: data/coords hold across bubbles, flags only with valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout_valid <= 1'b0;
         r_dout_data  <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_flags      <= '0;
         r_frame      <= '0;
      end else begin
         r_dout_valid <= w_acc;
         if (w_acc) begin
            r_dout_data <= bus.din_data;
            r_col       <= w_pix_col;
            r_row       <= w_pix_row;
            r_flags     <= w_flags;
            if (w_flags.eof) r_frame <= r_frame + FRAME_W'(1);
         end else begin
            r_flags     <= '0;
         end
      end
   end

   assign bus.dout_valid = r_dout_valid;
   assign bus.dout_data  = r_dout_data;
   assign bus.col_cnt    = r_col;
   assign bus.row_cnt    = r_row;
   assign bus.sof        = r_flags.sof;
   assign bus.eol        = r_flags.eol;
   assign bus.eof        = r_flags.eof;
   assign bus.border     = r_flags.border;
   assign bus.frame_cnt  = r_frame;
endmodule

// File: doc/img_coord_gen.md
Name: img_coord_gen

Overview:
- Parametrised pixel-coordinate generator for the rectification streaming path.
- Sits directly after the pixel source, ahead of window/remap stages.
- Registers each valid pixel together with its column/row coordinate, frame-boundary markers, border-region flags and a frame counter, so downstream blocks never keep their own counters.
- Successor to the fixed 640x480, 10-bit counter: widths derive from parameters, data passes through, and frame and border flags are added.

Parameters:
- DIN_DATA_WIDTH, 8, pixel data width.
- COL, 640, pixels per line; legal range is 2 or more.
- ROW, 480, lines per frame; legal range is 2 or more.
- COL_W, $clog2(COL), width of the column coordinate.
- ROW_W, $clog2(ROW), width of the row coordinate.
- BORDER, 1, border-flag thickness in pixels; must satisfy 1 <= BORDER <= min(COL,ROW)/2.
- FRAME_W, 8, frame counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- din_valid  in  1  input pixel qualifier; one pixel per cycle when high.
- din_data  in  DIN_DATA_WIDTH  input pixel.
- dout_valid  out  1  registered copy of din_valid.
- dout_data  out  DIN_DATA_WIDTH  registered pixel.
- col_cnt  out  COL_W  column of the pixel on dout_data.
- row_cnt  out  ROW_W  row of the pixel on dout_data.
- sof  out  1  pixel is (0,0).
- eol  out  1  pixel is at col COL-1.
- eof  out  1  pixel is (COL-1,ROW-1).
- border  out  1  pixel satisfies col<BORDER, col>=COL-BORDER, row<BORDER, or row>=ROW-BORDER.
- frame_cnt  out  FRAME_W  number of completed frames.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; every register clears immediately on assertion.
- Reset values: dout_valid=0, dout_data=0, col_cnt=0, row_cnt=0, sof=eol=eof=border=0, frame_cnt=0. The internal next-pixel counters nxt_col and nxt_row reset to 0.
- Latency: exactly 1 cycle from a din_valid pixel to its dout_valid. There is no backpressure and no ready signal.
- On a clk edge with din_valid=1:
  - dout_data <= din_data.
  - col_cnt <= nxt_col and row_cnt <= nxt_row.
  - sof, eol, eof and border are computed from (nxt_col, nxt_row) and registered.
  - nxt_col advances: it wraps to 0 at COL-1, otherwise increments.
  - nxt_row advances only when nxt_col==COL-1: it wraps to 0 at ROW-1, otherwise increments.
  - frame_cnt increments, modulo 2^FRAME_W, when the accepted pixel is eof.
- On a clk edge with din_valid=0:
  - dout_valid <= 0, and sof, eol, eof and border <= 0. Flags are only ever high together with dout_valid.
  - dout_data, col_cnt, row_cnt, nxt_col, nxt_row and frame_cnt hold.
- Gaps: bubbles in din_valid at any position, including mid-line and between frames, do not disturb the coordinate sequence.
- Wrap-around: the pixel after (COL-1,ROW-1) is (0,0) with sof=1.
- frame_cnt wrap: 2^FRAME_W-1 rolls over to 0 with no flag.
- Reset mid-frame: counters restart at (0,0); the next valid pixel is reported as sof.
- Arithmetic: all comparisons use the parameter-width counters. Compare constants are sized to COL_W/ROW_W with no truncation; when COL or ROW is a power of two, the counter still wraps via the explicit compare.

Optional Feature:
- Macro: IMG_COORD_SOF_RESYNC_EN.
- Defined:
  - Adds input din_sof (1 bit) and output sync_err (1 bit, reset 0).
  - When din_valid && din_sof, the pixel is reported as (0,0) with sof=1, and nxt_col=1, nxt_row=0 are loaded.
  - If (nxt_col,nxt_row) was not (0,0) at that moment, sync_err pulses high for 1 cycle, aligned with dout_valid.
  - frame_cnt is not incremented by a resync.
  - din_sof with din_valid=0 is ignored.
- Undefined: neither port exists, and the block is free-running as described above.

Decomposition:
- Package img_coord_pkg:
  - localparam function clog2_min1, which returns at least 1.
  - typedef of the flag bundle struct {sof, eol, eof, border}.
- Sub-module wrap_counter (params MAX, W; ports clk, rst, en, load, load_val, cnt, at_max) is instantiated twice: the column counter, and the row counter enabled by the column's at_max & en.

Test Plan:
- Use COL=4, ROW=3, BORDER=1.
- Reset, then 12 consecutive valid pixels with data 0..11 -> dout 1 cycle later. Coordinates run (0,0)..(3,2). sof on data 0; eol on 3, 7, 11; eof on 11. border high except data 5 and 6. frame_cnt=1 after data 11.
- Same 12 pixels with din_valid toggling 1,0,1,0,... -> identical coordinate/flag sequence; flags are 0 in bubble cycles.
- Assert rst asynchronously after pixel 6 (mid-cycle, no clk edge) -> outputs zero immediately; the next valid pixel reports (0,0) with sof=1 and frame_cnt=0.
- FRAME_W=2, stream 5 full frames -> frame_cnt reads 1, 2, 3, 0, 1 after each eof.
- With IMG_COORD_SOF_RESYNC_EN, din_sof on the 7th pixel -> that pixel is (0,0) with sof=1 and sync_err=1 for one cycle; the next pixel is (1,0). din_sof on a true (0,0) pixel -> sync_err=0.
